ram_init_engine: RTL and testbench
==================================

// Module: ram_init_engine
// PURPOSE
//   Parametrised successor to the single-mode 256x8 RAM initializer. Fills a single-port RAM of
//   DEPTH words with a selectable pattern (RC4 identity S-box, constant, descending, addr^key),
//   then optionally reads the RAM back and checks it. Sits between the top-level control FSM and
//   the working RAM port mux, ahead of the key-schedule and decrypt stages.
// PARAMETERS
//   ADDR_W    8    RAM address width
//   DATA_W    8    RAM data width
//   DEPTH     256  words to fill, 1..2**ADDR_W; need not be a power of two
//   READ_LAT  1    RAM read latency in cycles (>=1), address to ram_out valid
//   VERIFY_EN 1    1 = readback pass after fill; 0 = skip it
// PORTS
//   clk         in   1       single clock; all logic rising-edge
//   reset       in   1       asynchronous, active-high; clears all state and outputs
//   start       in   1       request, four-phase handshake with finished
//   mode        in   2       pattern select, sampled when a run starts
//   fill_value  in   DATA_W  constant / XOR key, sampled when a run starts
//   ram_out     in   DATA_W  RAM read data
//   write_enable out 1       RAM write strobe
//   address     out  ADDR_W  RAM address
//   ram_in      out  DATA_W  RAM write data
//   busy        out  1       high from first FILL cycle until DONE entered
//   finished    out  1       run complete
//   error       out  1       readback mismatch seen in last run (sticky until next run)
//   error_addr  out  ADDR_W  address of first mismatch
// BEHAVIOUR
//   - Reset: every output 0, FSM to IDLE; reset mid-run aborts immediately, no further writes.
//   - Patterns, data for address a (truncate/zero-extend to DATA_W): 00 IDENTITY a; 01 CONST
//     fill_value; 10 DESCEND DEPTH-1-a; 11 XOR a^fill_value. Mode/fill_value latched at IDLE->FILL.
//   - FSM IDLE->FILL->(VERIFY->DRAIN)->DONE->IDLE.
//   - IDLE: start sampled high -> FILL next cycle; error/error_addr cleared in same transition.
//   - FILL: write_enable=1 for exactly DEPTH consecutive cycles, address 0..DEPTH-1, one word per
//     cycle; first write cycle is 1 cycle after start sampled high. Terminal compare at DEPTH-1
//     (no reliance on counter wrap). Then VERIFY if VERIFY_EN else DONE.
//   - VERIFY: write_enable=0, address 0..DEPTH-1 one per cycle; expected data delayed READ_LAT
//     cycles alongside address. DRAIN holds READ_LAT cycles to compare the tail.
//   - Compare: ram_out != expected -> error=1; error_addr records first mismatch only.
//   - DONE: busy=0, finished=1; address/ram_in hold last value, write_enable=0. Leaves to IDLE the
//     cycle after start is sampled low; if start already low on entry, finished is 1 cycle wide.
//   - start falling mid-run is ignored; run completes. New run requires start low then high.
//   - Total cycles start->finished: 1+DEPTH (VERIFY_EN=0) or 1+2*DEPTH+READ_LAT (VERIFY_EN=1).
// STRUCTURE
//   - Package ram_init_pkg: mode enum (MODE_IDENTITY/CONST/DESCEND/XOR), FSM state enum,
//     pattern function pattern_f(mode, addr, fill_value, depth).
//   - Sub-module ram_init_delay_line #(WIDTH, LAT): LAT-stage register pipe with valid bit,
//     async reset to 0; carries {valid, addr, expected} to the comparator.
//   - Top: FSM, address counter, pattern mux, comparator, error capture.
// TESTING
//   - DEPTH=256, mode 00, VERIFY_EN=0, model RAM: start high -> writes addr 0..255 data=addr,
//     finished at cycle 257, held while start high; start low -> finished 0 next cycle.
//   - DEPTH=200, mode 11, fill_value 8'hA5: addr 199 written 8'h62; no write to 200..255;
//     mode/fill changed mid-run has no effect.
//   - VERIFY_EN=1, READ_LAT=2, RAM model corrupts addr 37 -> error=1, error_addr=37; second
//     corruption at 90 leaves error_addr=37; finished at cycle 1+2*DEPTH+2.
//   - Reset pulsed at FILL addr 100 -> all outputs 0 within reset assertion, no write after;
//     next start refills from addr 0.
//   - start dropped at addr 50 and pulsed again mid-run -> single run completes, 1-cycle finished,
//     no restart; start held high across DONE does not retrigger.
//   - mode 01 fill 8'h00 then mode 10: DESCEND writes addr 0 = 255, addr 255 = 0; error cleared.

Source files
------------

// File: rtl/ram_init_pkg.sv
// Shared types and the fill-pattern generator for the RAM init engine.
package ram_init_pkg;

    typedef enum logic [1:0] {
        MODE_IDENTITY = 2'b00,
        MODE_CONST    = 2'b01,
        MODE_DESCEND  = 2'b10,
        MODE_XOR      = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Computed 32 bits wide; callers truncate to their data width.
    function automatic logic [31:0] pattern_f(input mode_e mode, input logic [31:0] addr,
                                              input logic [31:0] fill_value,
                                              input int unsigned depth);
        logic [31:0] res;
        case (mode)
            MODE_IDENTITY: res = addr;
            MODE_CONST:    res = fill_value;
            MODE_DESCEND:  res = depth - 32'd1 - addr;
            default:       res = addr ^ fill_value;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ram_init_delay_line.sv
// LAT-stage register pipe with a valid bit; aligns readback address/expected data
// with the RAM read latency.
module ram_init_delay_line #(
    parameter int WIDTH = 16,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic [LAT-1:0]   valid_q;
    logic [WIDTH-1:0] data_q [LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/ram_init_engine.sv
// Fills DEPTH RAM words with a selectable pattern, optionally reads them back and
// flags the first mismatch.
// state    | meaning
// S_IDLE   | waiting for start
// S_FILL   | one write per cycle, address 0..DEPTH-1
// S_VERIFY | one read per cycle, address 0..DEPTH-1
// S_DRAIN  | READ_LAT cycles to compare the last reads
// S_DONE   | finished high until start is seen low
module ram_init_engine
    import ram_init_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 1,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] ram_out,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ram_in,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] error_addr
);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               we_q, we_d, busy_q, busy_d, fin_q, fin_d, err_q, err_d;
    logic [ADDR_W-1:0]  erra_q, erra_d;
    mode_e              mode_q, mode_d;
    logic [DATA_W-1:0]  fill_q, fill_d;
    logic [LAT_W-1:0]   drain_q, drain_d;

    logic               last_addr;
    logic [ADDR_W-1:0]  addr_nx;
    logic               pipe_valid;
    logic [ADDR_W-1:0]  pipe_addr;
    logic [DATA_W-1:0]  pipe_exp;

    function automatic logic [DATA_W-1:0] pat(input mode_e m, input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] f);
        logic [31:0] w;
        w = pattern_f(m, 32'(a), 32'(f), DEPTH);
        return w[DATA_W-1:0];
    endfunction

    assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
    assign addr_nx   = addr_q + ADDR_W'(1);

    ram_init_delay_line #(
        .WIDTH(ADDR_W + DATA_W),
        .LAT  (READ_LAT)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .valid_i(state_q == S_VERIFY),
        .data_i ({addr_q, pat(mode_q, addr_q, fill_q)}),
        .valid_o(pipe_valid),
        .data_o ({pipe_addr, pipe_exp})
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        err_d   = err_q;
        erra_d  = erra_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FILL;
                addr_d  = '0;
                we_d    = 1'b1;
                din_d   = pat(mode_e'(mode), '0, fill_value);
                busy_d  = 1'b1;
                err_d   = 1'b0;
                erra_d  = '0;
                mode_d  = mode_e'(mode);
                fill_d  = fill_value;
            end
            S_FILL: if (last_addr) begin
                if (VERIFY_EN != 0) begin
                    state_d = S_VERIFY;
                    addr_d  = '0;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                end
            end else begin
                addr_d = addr_nx;
                we_d   = 1'b1;
                din_d  = pat(mode_q, addr_nx, fill_q);
            end
            S_VERIFY: if (last_addr) begin
                state_d = S_DRAIN;
                drain_d = LAT_W'(READ_LAT - 1);
            end else begin
                addr_d = addr_nx;
            end
            S_DRAIN: if (drain_q == '0) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                fin_d   = 1'b1;
            end else begin
                drain_d = drain_q - LAT_W'(1);
            end
            S_DONE: if (!start) state_d = S_IDLE;
                    else        fin_d   = 1'b1;
            default: state_d = S_IDLE;
        endcase
        // Only the first mismatch of a run is recorded.
        if (pipe_valid && (ram_out != pipe_exp) && !err_q) begin
            err_d  = 1'b1;
            erra_d = pipe_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            erra_q  <= '0;
            mode_q  <= MODE_IDENTITY;
            fill_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            erra_q  <= erra_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            drain_q <= drain_d;
        end
    end

    assign write_enable = we_q;
    assign address      = addr_q;
    assign ram_in       = din_q;
    assign busy         = busy_q;
    assign finished     = fin_q;
    assign error        = err_q;
    assign error_addr   = erra_q;

endmodule

// File: tb/tb_ram_init_engine.sv
// Two engine instances (256 words no readback; 200 words readback with 2-cycle RAM)
// checked every cycle against a run-offset model and RAM scoreboards.
module tb_ram_init_engine;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0]      start_v = '0;
    logic [1:0][1:0] mode_v  = '0;
    logic [1:0][7:0] fill_v  = '0;
    logic [7:0]      rout0, rout1;
    logic [1:0]      we_w, busy_w, fin_w, err_w;
    logic [1:0][7:0] addr_w, din_w, erra_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_init_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .READ_LAT(1), .VERIFY_EN(0)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]), .fill_value(fill_v[0]),
        .ram_out(rout0), .write_enable(we_w[0]), .address(addr_w[0]), .ram_in(din_w[0]),
        .busy(busy_w[0]), .finished(fin_w[0]), .error(err_w[0]), .error_addr(erra_w[0]));

    ram_init_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .READ_LAT(2), .VERIFY_EN(1)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]), .fill_value(fill_v[1]),
        .ram_out(rout1), .write_enable(we_w[1]), .address(addr_w[1]), .ram_in(din_w[1]),
        .busy(busy_w[1]), .finished(fin_w[1]), .error(err_w[1]), .error_addr(erra_w[1]));

    function automatic int dep(input int i); return (i == 0) ? 256 : 200; endfunction
    function automatic bit ver(input int i); return i == 1; endfunction
    function automatic int lat(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int tot(input int i);
        return 1 + dep(i) + (ver(i) ? dep(i) + lat(i) : 0);
    endfunction

    function automatic int tb_pat(input int d, input int md, input int a, input int f);
        case (md)
            0:       return a & 255;
            1:       return f & 255;
            2:       return (d - 1 - a) & 255;
            default: return (a ^ f) & 255;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // RAM models: instance 0 one-cycle read, instance 1 two-cycle read; selected
    // addresses store the inverted word to provoke readback mismatches.
    logic [7:0] ram [2][256];
    logic [7:0] rd1 [2];
    logic [7:0] rd2 [2];
    int corr_a [2] = '{-1, -1};
    int corr_b [2] = '{-1, -1};
    bit ram_clr = 1'b1;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_clr) begin
                for (int j = 0; j < 256; j++) ram[i][j] <= 8'hEE;
            end else if (we_w[i]) begin
                ram[i][addr_w[i]] <= (int'(addr_w[i]) == corr_a[i] || int'(addr_w[i]) == corr_b[i])
                                     ? ~din_w[i] : din_w[i];
            end
            rd1[i] <= ram[i][addr_w[i]];
            rd2[i] <= rd1[i];
        end
    end
    assign rout0 = rd1[0];
    assign rout1 = rd2[1];

    // Model: phase (0 idle, 1 running, 2 done) and cycle offset k since start was sampled.
    int mst   [2] = '{0, 0};
    int mk    [2] = '{0, 0};
    int mmode [2] = '{0, 0};
    int mfill [2] = '{0, 0};
    bit mfresh[2] = '{1'b1, 1'b1};
    bit merr  [2] = '{1'b0, 1'b0};
    int merra [2] = '{0, 0};

    function automatic int first_bad(input int i);
        for (int a = 0; a < dep(i); a++)
            if (int'(ram[i][a]) != tb_pat(dep(i), mmode[i], a, mfill[i])) return a;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mst[i] <= 0; mfresh[i] <= 1'b1; merr[i] <= 1'b0; merra[i] <= 0;
            end else begin
                case (mst[i])
                    0: if (start_v[i]) begin
                        mst[i] <= 1; mk[i] <= 1;
                        mmode[i] <= int'(mode_v[i]); mfill[i] <= int'(fill_v[i]);
                        mfresh[i] <= 1'b0; merr[i] <= 1'b0; merra[i] <= 0;
                    end
                    1: if (mk[i] + 1 == tot(i)) begin
                        mst[i] <= 2;
                        if (ver(i)) begin
                            merr[i]  <= (first_bad(i) >= 0);
                            merra[i] <= (first_bad(i) >= 0) ? first_bad(i) : 0;
                        end
                    end else begin
                        mk[i] <= mk[i] + 1;
                    end
                    default: if (!start_v[i]) mst[i] <= 0;
                endcase
            end
        end
    end

    int ew, eb, ef, ea, ed, ee, eea, kk, dd;
    bit ca, cd, ce;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            dd = dep(i); ca = 1'b1; cd = 1'b1; ce = 1'b1;
            ew = 0; eb = 0; ef = 0; ea = 0; ed = 0; ee = 0; eea = 0;
            if (reset) begin
                ew = 0;
            end else if (mst[i] == 0) begin
                ca = mfresh[i]; cd = mfresh[i]; ee = int'(merr[i]); eea = merra[i];
            end else if (mst[i] == 1) begin
                kk = mk[i]; eb = 1;
                if (kk <= dd) begin
                    ew = 1; ea = kk - 1; ed = tb_pat(dd, mmode[i], kk - 1, mfill[i]);
                end else begin
                    cd = 1'b0; ce = 1'b0;
                    ea = (kk <= 2 * dd) ? kk - dd - 1 : dd - 1;
                end
            end else begin
                ef = 1; ea = dd - 1; ed = tb_pat(dd, mmode[i], dd - 1, mfill[i]);
                ee = int'(merr[i]); eea = merra[i];
            end
            chk($sformatf("inst%0d write_enable", i), int'(we_w[i]), ew);
            chk($sformatf("inst%0d busy", i), int'(busy_w[i]), eb);
            chk($sformatf("inst%0d finished", i), int'(fin_w[i]), ef);
            if (ca) chk($sformatf("inst%0d address", i), int'(addr_w[i]), ea);
            if (cd) chk($sformatf("inst%0d ram_in", i), int'(din_w[i]), ed);
            if (ce) begin
                chk($sformatf("inst%0d error", i), int'(err_w[i]), ee);
                chk($sformatf("inst%0d error_addr", i), int'(erra_w[i]), eea);
            end
        end
    end

    task automatic clear_ram();
        @(negedge clk); ram_clr = 1'b1;
        @(negedge clk); ram_clr = 1'b0;
    endtask

    // One handshake: raise start, scramble mode/fill while running, optionally drop
    // and re-pulse start mid-run, hold start for 'hold' cycles in DONE, then release.
    task automatic run_one(input int i, input int md, input int fv, input int hold,
                           input bit drop, input int exp_cycles);
        int  n;
        bit  done;
        @(negedge clk);
        mode_v[i] = 2'(md); fill_v[i] = 8'(fv); start_v[i] = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < LIMIT) begin
            @(posedge clk); n++; #1;
            if (fin_w[i]) done = 1'b1;
            else begin
                mode_v[i] = 2'($urandom_range(0, 3));
                fill_v[i] = 8'($urandom);
                if (drop) begin
                    if (n == 51) start_v[i] = 1'b0;
                    if (n == 80) start_v[i] = 1'b1;
                    if (n == 83) start_v[i] = 1'b0;
                end
            end
        end
        chk($sformatf("inst%0d cycles start->finished", i), n, exp_cycles);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("inst%0d finished held", i), int'(fin_w[i]), 1);
        end
        start_v[i] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("inst%0d finished after start low", i), int'(fin_w[i]), 0);
    endtask

    function automatic int ram_errors(input int i, input int md, input int f);
        int bad = 0;
        for (int a = 0; a < dep(i); a++)
            if (a != corr_a[i] && a != corr_b[i] && int'(ram[i][a]) != tb_pat(dep(i), md, a, f))
                bad++;
        return bad;
    endfunction

    initial begin
        int n, md, fv, bad;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0; ram_clr = 1'b0;
        #1;
        chk("reset address", int'(addr_w[0]), 0);
        chk("reset finished", int'(fin_w[1]), 0);

        // Identity fill, no readback, start held through DONE.
        run_one(0, 0, 8'h3C, 3, 1'b0, 257);
        bad = 0;
        for (int j = 0; j < 256; j++) if (int'(ram[0][j]) != j) bad++;
        chk("identity ram contents", bad, 0);

        // XOR 0xA5 on 200 words with readback.
        clear_ram();
        run_one(1, 3, 8'hA5, 0, 1'b0, 403);
        chk("xor ram[199]", int'(ram[1][199]), 8'h62);
        chk("xor ram[200] untouched", int'(ram[1][200]), 8'hEE);
        chk("xor ram[255] untouched", int'(ram[1][255]), 8'hEE);
        chk("xor clean error", int'(err_w[1]), 0);

        // Two corrupted words: only the first is reported.
        corr_a[1] = 37; corr_b[1] = 90;
        run_one(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 2, 1'b0, 403);
        chk("corrupt error", int'(err_w[1]), 1);
        chk("corrupt error_addr", int'(erra_w[1]), 37);
        corr_a[1] = -1; corr_b[1] = -1;

        // Constant 0x00 run clears the sticky error.
        run_one(1, 1, 8'h00, 0, 1'b0, 403);
        chk("error cleared", int'(err_w[1]), 0);
        chk("const ram[0]", int'(ram[1][0]), 0);

        // Reset while writing address 100.
        clear_ram();
        @(negedge clk); mode_v[0] = 2'd0; start_v[0] = 1'b1;
        n = 0;
        while (!(we_w[0] && addr_w[0] == 8'd100) && n < LIMIT) begin
            @(posedge clk); n++; #1;
        end
        chk("cycles to fill addr 100", n, 101);
        #1 reset = 1'b1;
        #1;
        chk("abort write_enable", int'(we_w[0]), 0);
        chk("abort address", int'(addr_w[0]), 0);
        chk("abort ram_in", int'(din_w[0]), 0);
        chk("abort busy", int'(busy_w[0]), 0);
        start_v[0] = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("abort ram[99]", int'(ram[0][99]), 99);
        chk("abort ram[100] unwritten", int'(ram[0][100]), 8'hEE);

        // Descending refill after the abort.
        run_one(0, 2, int'($urandom_range(0, 255)), 0, 1'b0, 257);
        chk("descend ram[0]", int'(ram[0][0]), 255);
        chk("descend ram[255]", int'(ram[0][255]), 0);
        chk("descend ram[100]", int'(ram[0][100]), 155);

        // start dropped at address 50 and re-pulsed mid-run: one run, 1-cycle finished.
        run_one(0, 3, int'($urandom_range(0, 255)), 0, 1'b1, 257);

        // Randomized runs with scoreboard comparison of RAM contents.
        for (int r = 0; r < 4; r++) begin
            int i;
            i = r % 2;
            md = int'($urandom_range(0, 3));
            fv = int'($urandom_range(0, 255));
            if (i == 1 && $urandom_range(0, 1) == 1) corr_a[1] = int'($urandom_range(0, 199));
            clear_ram();
            run_one(i, md, fv, int'($urandom_range(0, 3)), 1'b0, tot(i));
            chk($sformatf("random run %0d ram contents", r), ram_errors(i, md, fv), 0);
            corr_a[1] = -1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
